// File: rtl/psk_mod.sv
// PSK baseband modulator (BPSK/QPSK/8PSK per symbol) with one-entry symbol buffer,
// SPS-sample symbol hold, free-running carrier phase and offset-binary sine LUT output.
module psk_mod #(
   parameter int DATA_W       = 12,
   parameter int PHASE_W      = 6,
   parameter int SPS          = 64,
   parameter int CARRIER_STEP = 1,
   parameter int GRAY         = 1
) (
   input  logic              s_clk,
   input  logic              rst_n,
   input  logic              i_ce,
   input  logic [2:0]        i_sym,
   input  logic [1:0]        i_mode,
   input  logic              i_valid,
   output logic              o_ready,
   output logic [DATA_W-1:0] o_I,
   output logic [DATA_W-1:0] o_Q,
   output logic              o_active,
   output logic              o_sym_start,
   output logic              o_underrun
);

   localparam int N     = 2 ** PHASE_W;
   localparam int M     = 2 ** (DATA_W - 1);
   localparam int A     = M - 1;
   localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;

   localparam logic [PHASE_W-1:0] STEP     = PHASE_W'(CARRIER_STEP % N);
   localparam logic [PHASE_W-1:0] QTR      = PHASE_W'(N / 4);
   localparam logic [DATA_W-1:0]  MID      = DATA_W'(M);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SPS - 1);

   logic [DATA_W-1:0] lut [N];

   for (genvar k = 0; k < N; k++) begin : g_lut
      localparam real ANG = 2.0 * 3.14159265358979323846 * $itor(k) / $itor(N);
      localparam int  VAL = $rtoi($itor(M) + $itor(A) * $sin(ANG) + 0.5);
      assign lut[k] = DATA_W'(VAL);
   end

   // Symbol bits -> carrier phase offset for the captured modulation order
   function automatic logic [PHASE_W-1:0] sym_off(input logic [2:0] sym, input logic [1:0] mode);
      logic [2:0] idx8;
      logic [1:0] idx4;
      logic [PHASE_W-1:0] off;
      idx8 = sym;
      idx4 = sym[1:0];
      if (GRAY != 0) begin
         idx8 = {sym[2], sym[2] ^ sym[1], sym[2] ^ sym[1] ^ sym[0]};
         idx4 = {sym[1], sym[1] ^ sym[0]};
      end
      case (mode)
         2'd0:    off = PHASE_W'(sym[0]) << (PHASE_W - 1);
         2'd2:    off = PHASE_W'(idx8) << (PHASE_W - 3);
         default: off = PHASE_W'(idx4) << (PHASE_W - 2);
      endcase
      return off;
   endfunction

   logic [PHASE_W-1:0] acc;
   logic [PHASE_W-1:0] cur_off;
   logic [CNT_W-1:0]   cnt;
   logic               active;
   logic               buf_valid;
   logic [2:0]         buf_sym;
   logic [1:0]         buf_mode;
   logic               rdy_en;

   logic               load;
   logic               emit;
   logic [PHASE_W-1:0] ld_off;
   logic [PHASE_W-1:0] ps;
   logic [PHASE_W-1:0] pi_idx;
   logic [CNT_W-1:0]   cnt_nx;

   assign o_ready = rdy_en && !buf_valid;

   always_comb begin
      load   = (cnt == '0) && buf_valid;
      emit   = (cnt != '0) || buf_valid;
      ld_off = sym_off(buf_sym, buf_mode);
      ps     = acc + (load ? ld_off : cur_off);
      pi_idx = ps + QTR;
      cnt_nx = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
   end

   // Buffer accept and load are exclusive: accept needs it empty, load needs it full
   always_ff @(posedge s_clk or negedge rst_n) begin
      if (!rst_n) begin
         acc         <= '0;
         cur_off     <= '0;
         cnt         <= '0;
         active      <= 1'b0;
         buf_valid   <= 1'b0;
         buf_sym     <= '0;
         buf_mode    <= '0;
         rdy_en      <= 1'b0;
         o_I         <= MID;
         o_Q         <= MID;
         o_active    <= 1'b0;
         o_sym_start <= 1'b0;
         o_underrun  <= 1'b0;
      end else begin
         rdy_en      <= 1'b1;
         o_sym_start <= 1'b0;
         o_underrun  <= 1'b0;
         if (i_valid && o_ready) begin
            buf_valid <= 1'b1;
            buf_sym   <= i_sym;
            buf_mode  <= i_mode;
         end
         if (i_ce) begin
            acc <= acc + STEP;
            if (emit) begin
               o_Q      <= lut[ps];
               o_I      <= lut[pi_idx];
               o_active <= 1'b1;
               active   <= 1'b1;
               cnt      <= cnt_nx;
               if (load) begin
                  cur_off     <= ld_off;
                  buf_valid   <= 1'b0;
                  o_sym_start <= 1'b1;
               end
            end else begin
               o_Q        <= MID;
               o_I        <= MID;
               o_active   <= 1'b0;
               o_underrun <= active;
               active     <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_psk_mod.sv
// Self-checking bench for psk_mod: reference model feeds a sample scoreboard,
// per-scenario tasks add explicit spot checks on spec-defined values.
module tb_psk_mod;

   localparam int DATA_W = 12;
   localparam int PHASE_W = 6;
   localparam int SPS = 4;
   localparam int STEP = 1;
   localparam int GRAY = 1;
   localparam int N = 64;

   logic              s_clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_ce = 1'b0;
   logic [2:0]        i_sym = '0;
   logic [1:0]        i_mode = '0;
   logic              i_valid = 1'b0;
   logic              o_ready;
   logic [DATA_W-1:0] o_I;
   logic [DATA_W-1:0] o_Q;
   logic              o_active;
   logic              o_sym_start;
   logic              o_underrun;

   psk_mod #(
      .DATA_W(DATA_W),
      .PHASE_W(PHASE_W),
      .SPS(SPS),
      .CARRIER_STEP(STEP),
      .GRAY(GRAY)
   ) dut (
      .s_clk(s_clk),
      .rst_n(rst_n),
      .i_ce(i_ce),
      .i_sym(i_sym),
      .i_mode(i_mode),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .o_I(o_I),
      .o_Q(o_Q),
      .o_active(o_active),
      .o_sym_start(o_sym_start),
      .o_underrun(o_underrun)
   );

   always #5 s_clk = ~s_clk;

   typedef struct {
      logic [11:0] i;
      logic [11:0] q;
      logic        act;
      logic        ss;
      logic        ur;
   } samp_t;

   typedef struct {
      logic [2:0] s;
      logic [1:0] m;
   } sym_t;

   samp_t sb[$];
   samp_t last;
   sym_t  tx_q[$];
   int    checks = 0;
   int    errors = 0;
   string cur_test = "init";

   int         m_acc, m_cnt, m_off;
   logic       m_act, m_bv, m_rdy;
   logic [2:0] m_bsym;
   logic [1:0] m_bmode;
   int         n_start, n_under;

   function automatic logic [11:0] lut_val(input int k);
      real a;
      a = 2048.0 + 2047.0 * $sin(2.0 * 3.14159265358979 * k / N);
      return 12'($rtoi(a + 0.5));
   endfunction

   function automatic int ref_off(input logic [2:0] s, input logic [1:0] m);
      int qmap[4] = '{0, 1, 3, 2};
      int idx;
      case (m)
         2'd0: return s[0] * (N / 2);
         2'd2: begin
            idx = s;
            if (GRAY != 0) idx = s ^ (s >> 1) ^ (s >> 2);
            return idx * (N / 8);
         end
         default: return (GRAY != 0 ? qmap[s[1:0]] : int'(s[1:0])) * (N / 4);
      endcase
   endfunction

   task automatic model_reset();
      m_acc = 0; m_cnt = 0; m_off = 0;
      m_act = 1'b0; m_bv = 1'b0; m_rdy = 1'b0;
      m_bsym = '0; m_bmode = '0;
      last = '{12'h800, 12'h800, 1'b0, 1'b0, 1'b0};
      sb.delete();
      tx_q.delete();
   endtask

   task automatic step(input logic ce, input logic v, input logic [2:0] s, input logic [1:0] m,
                       output logic took);
      samp_t e;
      logic  exp_rdy;
      int    ps;
      i_ce = ce; i_valid = v; i_sym = s; i_mode = m;
      exp_rdy = m_rdy && !m_bv;
      checks++;
      if (o_ready !== exp_rdy) begin
         errors++;
         $display("FAIL %s ready: got %b want %b", cur_test, o_ready, exp_rdy);
      end
      took = v && exp_rdy;
      e = last;
      e.ss = 1'b0;
      e.ur = 1'b0;
      if (ce) begin
         if (m_cnt != 0 || m_bv) begin
            if (m_cnt == 0) begin
               m_off = ref_off(m_bsym, m_bmode);
               m_bv = 1'b0;
               e.ss = 1'b1;
            end
            ps = (m_acc + m_off) % N;
            e.q = lut_val(ps);
            e.i = lut_val((ps + N / 4) % N);
            e.act = 1'b1;
            m_act = 1'b1;
            m_cnt = (m_cnt + 1) % SPS;
         end else begin
            e.i = 12'h800; e.q = 12'h800; e.act = 1'b0;
            e.ur = m_act;
            m_act = 1'b0;
         end
         m_acc = (m_acc + STEP) % N;
      end
      if (took) begin
         m_bv = 1'b1; m_bsym = s; m_bmode = m;
      end
      m_rdy = 1'b1;
      sb.push_back(e);
      @(posedge s_clk);
      #1;
      e = sb.pop_front();
      checks++;
      if ({o_I, o_Q, o_active, o_sym_start, o_underrun} !== {e.i, e.q, e.act, e.ss, e.ur}) begin
         errors++;
         $display("FAIL %s sample: got I=%h Q=%h act=%b ss=%b ur=%b want I=%h Q=%h act=%b ss=%b ur=%b",
                  cur_test, o_I, o_Q, o_active, o_sym_start, o_underrun, e.i, e.q, e.act, e.ss, e.ur);
      end
      last = e;
      n_start += int'(o_sym_start);
      n_under += int'(o_underrun);
   endtask

   task automatic run_stream(input int cycles, input int ce_period);
      logic ce, took;
      sym_t h;
      for (int c = 0; c < cycles; c++) begin
         ce = ((c % ce_period) == 0);
         if (tx_q.size() > 0) begin
            h = tx_q[0];
            step(ce, 1'b1, h.s, h.m, took);
            if (took) void'(tx_q.pop_front());
         end else begin
            step(ce, 1'b0, 3'b000, 2'd0, took);
         end
      end
      i_valid = 1'b0;
      checks++;
      if (tx_q.size() != 0) begin
         errors++;
         $display("FAIL %s drain: got %0d symbols left want 0", cur_test, tx_q.size());
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      if ({o_I, o_Q, o_active, o_ready, o_sym_start, o_underrun} !== {12'h800, 12'h800, 4'b0000}) begin
         errors++;
         $display("FAIL %s: got I=%h Q=%h act=%b rdy=%b ss=%b ur=%b want I=800 Q=800 act=0 rdy=0 ss=0 ur=0",
                  tag, o_I, o_Q, o_active, o_ready, o_sym_start, o_underrun);
      end
   endtask

   task automatic check_count(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s %s: got %0d want %0d", cur_test, tag, got, want);
      end
   endtask

   task automatic release_reset();
      logic took;
      @(negedge s_clk);
      rst_n = 1'b1;
      model_reset();
      step(1'b0, 1'b0, 3'b000, 2'd0, took);
      checks++;
      if (o_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_after_reset: got %b want 1", cur_test, o_ready);
      end
   endtask

   task automatic test_reset();
      cur_test = "reset";
      model_reset();
      #12;
      check_idle_outputs("reset_hold");
      release_reset();
   endtask

   task automatic test_qpsk();
      logic took;
      cur_test = "qpsk";
      n_start = 0; n_under = 0;
      step(1'b0, 1'b1, 3'b011, 2'd1, took);
      step(1'b1, 1'b0, 3'b000, 2'd0, took);
      checks++;
      if ({o_I, o_Q, o_sym_start, o_active} !== {12'h001, 12'h800, 2'b11}) begin
         errors++;
         $display("FAIL qpsk first: got I=%h Q=%h ss=%b act=%b want I=001 Q=800 ss=1 act=1",
                  o_I, o_Q, o_sym_start, o_active);
      end
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 3'b000, 2'd0, took);
      step(1'b1, 1'b0, 3'b000, 2'd0, took);
      checks++;
      if ({o_I, o_Q, o_underrun, o_active} !== {12'h800, 12'h800, 2'b10}) begin
         errors++;
         $display("FAIL qpsk underrun: got I=%h Q=%h ur=%b act=%b want I=800 Q=800 ur=1 act=0",
                  o_I, o_Q, o_underrun, o_active);
      end
      step(1'b1, 1'b0, 3'b000, 2'd0, took);
      check_count("underrun_pulses", n_under, 1);
   endtask

   task automatic test_back_to_back();
      cur_test = "back_to_back";
      n_start = 0; n_under = 0;
      tx_q.push_back('{3'b001, 2'd0});
      tx_q.push_back('{3'b000, 2'd0});
      run_stream(12, 1);
      check_count("sym_starts", n_start, 2);
      check_count("underruns", n_under, 1);
   endtask

   task automatic test_8psk();
      logic [2:0] g;
      cur_test = "8psk";
      n_start = 0; n_under = 0;
      for (int k = 0; k < 8; k++) begin
         g = 3'(k) ^ (3'(k) >> 1);
         tx_q.push_back('{g, 2'd2});
      end
      run_stream(8 * SPS + 6, 1);
      check_count("sym_starts", n_start, 8);
      check_count("underruns", n_under, 1);
   endtask

   task automatic test_backpressure();
      cur_test = "backpressure";
      n_start = 0; n_under = 0;
      tx_q.push_back('{3'b010, 2'd1});
      tx_q.push_back('{3'b001, 2'd1});
      tx_q.push_back('{3'b011, 2'd1});
      run_stream(90, 5);
      check_count("sym_starts", n_start, 3);
      check_count("underruns", n_under, 1);
   endtask

   task automatic test_wrap();
      cur_test = "wrap";
      n_start = 0; n_under = 0;
      for (int k = 0; k < 26; k++) tx_q.push_back('{3'(k * 3), (k % 2 == 0) ? 2'd3 : 2'd1});
      run_stream(110, 1);
      check_count("sym_starts", n_start, 26);
   endtask

   task automatic test_reset_mid();
      cur_test = "reset_mid";
      n_start = 0; n_under = 0;
      tx_q.push_back('{3'b001, 2'd1});
      tx_q.push_back('{3'b010, 2'd1});
      run_stream(3, 1);
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("reset_mid_hold");
      release_reset();
      n_start = 0;
      tx_q.push_back('{3'b110, 2'd2});
      run_stream(8, 1);
      check_count("sym_starts", n_start, 1);
   endtask

   initial begin
      test_reset();
      test_qpsk();
      test_back_to_back();
      test_8psk();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
